// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window fetch path.
// Holds the fetch FSM encoding, pixel/window sizing and the coordinate clamp.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } fetch_state_t;

  localparam int PIX_W   = 8;
  localparam int WIN_N   = 9;
  localparam int COORD_W = 16;
  localparam int K_W     = 4;

  typedef logic [PIX_W-1:0] pixel_t;

  // Edge replication: pull a signed neighbour coordinate back into [0, hi].
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W:0] v,
    input logic [COORD_W-1:0]      hi
  );
    logic [COORD_W-1:0] res;
    if (v < 17'sd0) begin
      res = {COORD_W{1'b0}};
    end else if (v > $signed({1'b0, hi})) begin
      res = hi;
    end else begin
      res = v[COORD_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational address generator: maps centre (x,y) and tap k of the 3x3
// window to a frame-memory address with clamped (edge-replicated) borders.
module window_addr_gen
  import sobel_pkg::*;
#(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [K_W-1:0]     k,
  output logic [31:0]        inaddr
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] MAX_R = COORD_W'(IMG_HEIGHT - 1);

  logic [1:0]                dr_s;
  logic [1:0]                dc_s;
  logic signed [COORD_W:0]   row_s;
  logic signed [COORD_W:0]   col_s;
  logic [COORD_W-1:0]        r_s;
  logic [COORD_W-1:0]        c_s;

  // Tap decode, signed neighbour coordinates, clamp and row-major address.
  always_comb begin
    dr_s = 2'd0;
    dc_s = 2'd0;
    case (k)
      4'd0:    begin dr_s = 2'd0; dc_s = 2'd0; end
      4'd1:    begin dr_s = 2'd0; dc_s = 2'd1; end
      4'd2:    begin dr_s = 2'd0; dc_s = 2'd2; end
      4'd3:    begin dr_s = 2'd1; dc_s = 2'd0; end
      4'd4:    begin dr_s = 2'd1; dc_s = 2'd1; end
      4'd5:    begin dr_s = 2'd1; dc_s = 2'd2; end
      4'd6:    begin dr_s = 2'd2; dc_s = 2'd0; end
      4'd7:    begin dr_s = 2'd2; dc_s = 2'd1; end
      4'd8:    begin dr_s = 2'd2; dc_s = 2'd2; end
      default: begin dr_s = 2'd0; dc_s = 2'd0; end
    endcase
    // 17-bit signed so that the -1 offset at row/column 0 goes negative.
    row_s  = $signed({1'b0, y}) + $signed({15'd0, dr_s}) - 17'sd1;
    col_s  = $signed({1'b0, x}) + $signed({15'd0, dc_s}) - 17'sd1;
    r_s    = clamp_coord(row_s, MAX_R);
    c_s    = clamp_coord(col_s, MAX_C);
    inaddr = BASE_ADDR + (32'(r_s) * 32'(IMG_WIDTH)) + 32'(c_s);
  end

endmodule

// File: rtl/sobel_window_fetch.sv
// Raster-order 3x3 window fetcher: one master read per tap, nine taps per
// window, each finished window handed to the Sobel stage over valid/ready.
module sobel_window_fetch
  import sobel_pkg::*;
#(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     readen,
  output logic [31:0]              inaddr,
  input  logic [31:0]              readdata,
  input  logic                     dataready,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [WIN_N*PIX_W-1:0]   win,
  output logic [COORD_W-1:0]       win_x,
  output logic [COORD_W-1:0]       win_y,
  output logic                     busy,
  output logic                     done
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(IMG_HEIGHT - 1);

  fetch_state_t         state_r;
  fetch_state_t         state_s;
  logic [COORD_W-1:0]   x_r;
  logic [COORD_W-1:0]   y_r;
  logic [K_W-1:0]       k_r;
  logic [COORD_W-1:0]   x_s;
  logic [COORD_W-1:0]   y_s;
  logic [K_W-1:0]       k_s;
  logic                 store_en_s;
  logic [31:0]          addr_s;
  pixel_t               pix_s;
  logic                 unused_s;

  assign pix_s    = readdata[PIX_W-1:0];
  assign unused_s = ^readdata[31:PIX_W];

  // Address is computed from the next-state coordinates so it registers
  // alongside readen on entry to REQ.
  window_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_gen (
    .x      (x_s),
    .y      (y_s),
    .k      (k_s),
    .inaddr (addr_s)
  );

  // Next-state logic and raster/tap counter updates.
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    k_s        = k_r;
    store_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        x_s = {COORD_W{1'b0}};
        y_s = {COORD_W{1'b0}};
        k_s = {K_W{1'b0}};
        if (start) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (dataready) begin
          store_en_s = 1'b1;
          if (k_r == 4'd8) begin
            state_s = ST_EMIT;
          end else begin
            k_s     = k_r + 4'd1;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (win_ready) begin
          k_s = {K_W{1'b0}};
          if (x_r < LAST_X) begin
            x_s     = x_r + 16'd1;
            state_s = ST_REQ;
          end else if (y_r < LAST_Y) begin
            x_s     = {COORD_W{1'b0}};
            y_s     = y_r + 16'd1;
            state_s = ST_REQ;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      x_r       <= {COORD_W{1'b0}};
      y_r       <= {COORD_W{1'b0}};
      k_r       <= {K_W{1'b0}};
      readen    <= 1'b0;
      inaddr    <= 32'h0;
      win_valid <= 1'b0;
      win_x     <= {COORD_W{1'b0}};
      win_y     <= {COORD_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      y_r       <= y_s;
      k_r       <= k_s;
      readen    <= (state_s == ST_REQ);
      if (state_s == ST_REQ) begin
        inaddr <= addr_s;
      end
      win_valid <= (state_s == ST_EMIT);
      if ((state_s == ST_EMIT) && (state_r != ST_EMIT)) begin
        win_x <= x_r;
        win_y <= y_r;
      end
      busy      <= (state_s != ST_IDLE);
      done      <= (state_s == ST_DONE);
    end
  end

  // Nine-slot window store; only written in WAIT, so it is frozen in EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= {(WIN_N*PIX_W){1'b0}};
    end else begin
      for (int i = 0; i < WIN_N; i++) begin
        if (store_en_s && (k_r == K_W'(i))) begin
          win[PIX_W*i +: PIX_W] <= pix_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Scoreboard bench for sobel_window_fetch on a 4x3 image: stimulus queues
// expected addresses/windows, negedge monitors pop and compare.
module tb_sobel_window_fetch;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        readen;
  logic [31:0] inaddr;
  logic [31:0] readdata;
  logic        dataready;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win;
  logic [15:0] win_x;
  logic [15:0] win_y;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sobel_window_fetch #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .readen    (readen),
    .inaddr    (inaddr),
    .readdata  (readdata),
    .dataready (dataready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win       (win),
    .win_x     (win_x),
    .win_y     (win_y),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [71:0] w;
    logic [15:0] x;
    logic [15:0] y;
  } exp_win_t;

  exp_win_t wq[$];
  int       aq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int wn_cnt  = 0;
  int done_cnt = 0;
  int cyc     = 0;
  int hs_cyc  = 0;
  int done_cyc = 0;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int       exp_a;
  exp_win_t exp_w;

  // Hand-computed reference vectors for windows (0,0) and (3,0).
  int a00[9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
  int a30[9] = '{2, 3, 3, 2, 3, 3, 6, 7, 7};
  localparam logic [71:0] WIN00 = {8'd20, 8'd16, 8'd16, 8'd4, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0};
  localparam logic [71:0] WIN30 = {8'd28, 8'd28, 8'd24, 8'd12, 8'd12, 8'd8, 8'd12, 8'd12, 8'd8};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int ref_addr(input int x, input int y, input int k);
    int r;
    int c;
    r = y + (k / 3) - 1;
    c = x + (k % 3) - 1;
    if (r < 0) r = 0;
    if (r > H - 1) r = H - 1;
    if (c < 0) c = 0;
    if (c > W - 1) c = W - 1;
    return r * W + c;
  endfunction

  task automatic push_frame();
    exp_win_t e;
    int a;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.w = 72'h0;
        e.x = 16'(x);
        e.y = 16'(y);
        for (int k = 0; k < 9; k++) begin
          if (x == 0 && y == 0) a = a00[k];
          else if (x == 3 && y == 0) a = a30[k];
          else a = ref_addr(x, y, k);
          aq.push_back(a);
          e.w[8*k +: 8] = 8'(a * 4);
        end
        if (x == 0 && y == 0) e.w = WIN00;
        else if (x == 3 && y == 0) e.w = WIN30;
        wq.push_back(e);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readen"}, readen, 0);
    check({tag, "_inaddr"}, inaddr, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_win_x"}, win_x, 0);
    check({tag, "_win_y"}, win_y, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic pulse_start_and_check();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_readen", readen, 1);
    check("start_inaddr", inaddr, 0);
  endtask

  task automatic run_to_done(input int target);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
      start = ((guard % 37) == 0 && busy === 1'b1 && done !== 1'b1) ? 1'b1 : 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_seen", done_cnt, target);
  endtask

  // Memory model: returns addr*4 two cycles after each readen.
  always @(negedge clk) begin
    dataready = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        dataready = 1'b1;
        readdata  = mem_addr * 32'd4;
      end
    end
    if (readen === 1'b1) begin
      mem_cnt  = 2;
      mem_addr = inaddr;
    end
  end

  // Monitor: read addresses, accepted windows and done pulses.
  always @(negedge clk) begin
    cyc++;
    if (readen === 1'b1) begin
      rd_cnt++;
      if (aq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_readen: got addr %0d, required no read", inaddr);
      end else begin
        exp_a = aq.pop_front();
        check("rd_addr", inaddr, exp_a);
      end
    end
    if (win_valid === 1'b1 && win_ready === 1'b1) begin
      wn_cnt++;
      hs_cyc = cyc;
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_window: got (%0d,%0d), required no window", win_x, win_y);
      end else begin
        exp_w = wq.pop_front();
        check("win_data", win, exp_w.w);
        check("win_x", win_x, exp_w.x);
        check("win_y", win_y, exp_w.y);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int found;
    rst       = 1'b1;
    start     = 1'b1;
    win_ready = 1'b0;
    dataready = 1'b0;
    readdata  = 32'h0;

    // Reset held with start asserted.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst   = 1'b0;
    start = 1'b0;

    // Frame 1: stall the first window, then run to completion.
    rd_cnt = 0; wn_cnt = 0; done_cnt = 0;
    push_frame();
    pulse_start_and_check();
    n = 0;
    while (win_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("win0_valid", win_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", win_valid, 1);
      check("hold_win", win, WIN00);
      check("hold_readen", readen, 0);
    end
    win_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (readen === 1'b1) found = 1;
    end
    check("readen_resume", found, 1);
    run_to_done(1);
    check("f1_windows", wn_cnt, 12);
    check("f1_readen", rd_cnt, 108);
    check("f1_done_latency", done_cyc, hs_cyc + 1);
    check("f1_aq_empty", aq.size(), 0);
    check("f1_wq_empty", wq.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    check("f1_idle_busy", busy, 0);
    check("f1_no_restart", rd_cnt, 108);
    check("f1_done_once", done_cnt, 1);

    // Reset during WAIT of the 5th read; its dataready lands in IDLE.
    rd_cnt = 0; wn_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 5; k++) aq.push_back(a00[k]);
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    found = 0;
    while (n < 5 && found < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      found++;
      if (readen === 1'b1) n++;
    end
    check("mid_reads_seen", n, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_all_zero("midrst");
    repeat (6) @(posedge clk);
    #1;
    check("midrst_win_valid", win_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_readen_cnt", rd_cnt, 5);
    check("midrst_no_window", wn_cnt, 0);
    check("midrst_aq_empty", aq.size(), 0);

    // Restart after the aborted frame.
    rd_cnt = 0; wn_cnt = 0; done_cnt = 0;
    push_frame();
    pulse_start_and_check();
    run_to_done(1);
    check("f2_windows", wn_cnt, 12);
    check("f2_readen", rd_cnt, 108);
    check("f2_done_latency", done_cyc, hs_cyc + 1);
    check("f2_aq_empty", aq.size(), 0);
    check("f2_wq_empty", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_fetch.md
# sobel_window_fetch

Upstream request generator for the Avalon master FSM in the Sobel edge-detection datapath. On `start` it walks the image in raster order and fetches the 3x3 neighbourhood of every pixel from frame memory, one master read per pixel, with edge-replicated borders. Each completed 72-bit window goes to the Sobel compute stage over a valid/ready handshake.

## Interface
- `IMG_WIDTH`, 640: pixels per row (≥2)
- `IMG_HEIGHT`, 480: rows per frame (≥2)
- `BASE_ADDR`, 32'h0: address of pixel (0,0); bit 31 must be 0
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a frame when IDLE
- `readen`  out  1  read request to master FSM
- `inaddr`  out  32  read address to master FSM
- `readdata`  in  32  master read data; pixel in [7:0]
- `dataready`  in  1  master read data valid, one-cycle pulse
- `win_valid`  out  1  window available
- `win_ready`  in  1  compute stage accepts window
- `win`  out  72  window; pixel k at [8k+7:8k], k = 3*dr+dc, row-major, k=0 top-left
- `win_x`  out  16  centre column of current window
- `win_y`  out  16  centre row of current window
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse after the last window is accepted

## Operation
- States: IDLE, REQ, WAIT, EMIT, DONE.
- IDLE: `x=y=k=0`. `start` moves to REQ. `start` is ignored in every other state.
- REQ (1 cycle): `readen=1`, `inaddr=BASE_ADDR + r*IMG_WIDTH + c`. `r = clamp(y+k/3-1, 0, IMG_HEIGHT-1)`, `c = clamp(x+k%3-1, 0, IMG_WIDTH-1)`. Next state is WAIT.
- WAIT: `readen=0`, `inaddr` held. On `dataready`, store `readdata[7:0]` into slot k. If k=8, go to EMIT; otherwise k++ and go to REQ. `dataready` seen in REQ or in any state other than WAIT is ignored.
- EMIT: `win_valid=1`. `win`, `win_x`, `win_y` are stable until accepted. On `win_valid & win_ready`, set k=0, then:
  - if x<IMG_WIDTH-1: x++, go to REQ
  - else if y<IMG_HEIGHT-1: x=0, y++, go to REQ
  - else go to DONE
- DONE (1 cycle): `done=1`, then IDLE.
- Arithmetic: compute row and column signed in 17 bits before clamping. The address multiply and add are 32-bit unsigned and wrap modulo 2^32; the parameter rule on `BASE_ADDR` prevents overflow in legal configurations.
- Reset: all outputs and internal registers go to 0 (including `win`, `win_x`, `win_y`), and the state goes to IDLE. `rst` asserted mid-fetch abandons the window. A `dataready` arriving after reset is ignored because the state is IDLE.

## Timing
- Reset values: `readen=0`, `inaddr=0`, `win_valid=0`, `win=0`, `win_x=0`, `win_y=0`, `busy=0`, `done=0`.
- `readen` is asserted exactly one cycle per request. At most one read is outstanding.
- A request occupies REQ plus WAIT, so it takes ≥2 cycles. A window therefore takes ≥18 cycles plus the EMIT cycle(s).
- `win_valid` rises the cycle after the 9th `dataready`. It falls the cycle after it is accepted.
- No new `readen` is issued while `win_valid=1` and `win_ready=0`.
- `done` is asserted the cycle after the final handshake. `busy` falls together with `done` deasserting.

## Structure
- Shared package `sobel_pkg` holds:
  - `fetch_state_t` enum
  - `PIX_W=8`, `WIN_N=9`
  - `typedef logic [PIX_W-1:0] pixel_t`
- Sub-module `window_addr_gen` (combinational): inputs x, y, k; output `inaddr`. It contains the clamp and the multiply-add.
- Registers, the FSM and the 9-entry window store live in the top.

## Test plan
All scenarios use `IMG_WIDTH=4`, `IMG_HEIGHT=3`, `BASE_ADDR=0`. The memory model returns `readdata = addr*4`, with `dataready` 2 cycles after `readen`.
- Hold `rst` 3 cycles with `start=1` → all outputs 0 and `busy=0`. After `rst` drops, a `start` pulse → `readen`=1 on the next cycle with `inaddr=0`.
- First window (0,0) → address sequence 0,0,1,0,0,1,4,4,5; `win` bytes k0..k8 = 0,0,4,0,0,4,16,16,20; `win_x=0`, `win_y=0`.
- Window (3,0) accepted → next window is (0,1). (3,0) addresses are 2,3,3,2,3,3,6,7,7; the first (0,1) address is 0.
- Hold `win_ready=0` for 10 cycles at the first window → `win_valid` stays 1, `win` is unchanged and `readen` stays 0. Raising `win_ready` → `readen` follows within 2 cycles.
- Full frame with `win_ready=1` → 12 windows and 108 `readen` pulses. `done` pulses once, one cycle after the window at (3,2) is accepted; `start` pulses sent while busy have no effect.
- Assert `rst` in WAIT during the 5th read, then deliver `dataready` → state is IDLE, outputs are 0 and no window is emitted. A new `start` restarts at address 0.
